// File: rtl/lsu_store_buffer_if.sv
// Request, response and memory-port bundle of the MEM-stage load/store unit.
// The slave side belongs to the LSU; the master side is the pipeline plus memory.
interface lsu_store_buffer_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [2:0]  reqSize;
  logic [31:0] reqWData;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspErr;
  logic        memGnt;
  logic [31:0] memAddr;
  logic [2:0]  memSize;
  logic [31:0] memWData;
  logic        memWEn;
  logic [31:0] memRData;
  logic        sbEmpty;

  modport slave (
    input  reqValid, reqWrite, reqAddr,
    input  reqSize, reqWData,
    input  memGnt, memRData,
    output reqReady, rspValid, rspData,
    output rspErr, memAddr, memSize,
    output memWData, memWEn, sbEmpty
  );

  modport master (
    output reqValid, reqWrite, reqAddr,
    output reqSize, reqWData,
    output memGnt, memRData,
    input  reqReady, rspValid, rspData,
    input  rspErr, memAddr, memSize,
    input  memWData, memWEn, sbEmpty
  );
endinterface

// File: rtl/lsu_store_buffer.sv
// MEM-stage load/store unit: posted stores drain from a FIFO,
// loads issue only when the FIFO is empty.
module lsu_store_buffer #(
  parameter int SB_DEPTH = 4
) (
  input logic            clk,
  input logic            rstN,
  lsu_store_buffer_if.slave bus
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e        state_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_addr_q [SB_DEPTH];
  logic [2:0]    fifo_size_q [SB_DEPTH];
  logic [31:0]   fifo_data_q [SB_DEPTH];
  logic          rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_data_q;

  logic legal, ready, full, empty;
  logic acc, push, pop, ld;
  logic a_h, a_w;

  function automatic logic [31:0] ld_ext(
    input logic [2:0]  sz,
    input logic [31:0] d
  );
    case (sz)
      3'b000:  ld_ext = {{24{d[7]}}, d[7:0]};
      3'b001:  ld_ext = {{16{d[15]}}, d[15:0]};
      3'b100:  ld_ext = {24'd0, d[7:0]};
      3'b101:  ld_ext = {16'd0, d[15:0]};
      default: ld_ext = d;
    endcase
  endfunction

  assign a_h   = ~bus.reqAddr[0];
  assign a_w   = bus.reqAddr[1:0] == 2'b00;
  assign full  = count_q == CW'(SB_DEPTH);
  assign empty = count_q == '0;

  always_comb begin
    legal = 1'b0;
    case (bus.reqSize)
      3'b000:  legal = 1'b1;
      3'b001:  legal = a_h;
      3'b010:  legal = a_w;
      3'b100:  legal = ~bus.reqWrite;
      3'b101:  legal = ~bus.reqWrite & a_h;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    ready = 1'b1;
    if (legal) begin
      if (bus.reqWrite) ready = ~full;
      else              ready = empty & bus.memGnt;
    end
  end

  assign acc  = bus.reqValid & ready;
  assign push = acc & legal & bus.reqWrite;
  assign ld   = acc & legal & ~bus.reqWrite;
  assign pop  = (state_q == DRAIN) & bus.memGnt;

  always_comb begin
    count_d = count_q;
    if (push & ~pop)      count_d = count_q + 1'b1;
    else if (pop & ~push) count_d = count_q - 1'b1;
  end

  // Loads are only accepted while empty, so pop and ld never overlap.
  always_comb begin
    bus.memAddr  = 32'd0;
    bus.memSize  = 3'b011;
    bus.memWData = 32'd0;
    bus.memWEn   = 1'b0;
    unique case (1'b1)
      pop: begin
        bus.memAddr  = fifo_addr_q[rd_ptr_q];
        bus.memSize  = fifo_size_q[rd_ptr_q];
        bus.memWData = fifo_data_q[rd_ptr_q];
        bus.memWEn   = 1'b1;
      end
      ld: begin
        bus.memAddr = bus.reqAddr;
        bus.memSize = bus.reqSize;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.reqAddr;
      fifo_size_q[wr_ptr_q] <= bus.reqSize;
      fifo_data_q[wr_ptr_q] <= bus.reqWData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      unique case (state_q)
        IDLE:    if (count_d != '0) state_q <= DRAIN;
        DRAIN:   if (count_d == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      rsp_valid_q <= acc;
      rsp_err_q   <= acc & ~legal;
      rsp_data_q  <= ld ? ld_ext(bus.reqSize, bus.memRData) : 32'd0;
    end
  end

  assign bus.reqReady = ready;
  assign bus.rspValid = rsp_valid_q;
  assign bus.rspErr   = rsp_err_q;
  assign bus.rspData  = rsp_data_q;
  assign bus.sbEmpty  = empty;
endmodule

// File: tb/tb_lsu_store_buffer.sv
// Directed bench for lsu_store_buffer with a little-endian byte memory
// that returns the addressed bytes in the low lanes.
module tb_lsu_store_buffer;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wen_cnt = 0;

  logic [7:0]  mem [1024];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];

  lsu_store_buffer_if bus();

  lsu_store_buffer #(.SB_DEPTH(4)) dut (
    .clk(clk),
    .rstN(rstN),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    logic [9:0] a;
    a = bus.memAddr[9:0];
    bus.memRData = {mem[a + 10'd3], mem[a + 10'd2],
                    mem[a + 10'd1], mem[a]};
  end

  always @(posedge clk) begin
    logic [9:0] a;
    a = bus.memAddr[9:0];
    if (bus.memWEn) begin
      log_addr.push_back(bus.memAddr);
      log_data.push_back(bus.memWData);
      log_cyc.push_back(cyc);
      mem[a] <= bus.memWData[7:0];
      if (bus.memSize != 3'b000)
        mem[a + 10'd1] <= bus.memWData[15:8];
      if (bus.memSize == 3'b010) begin
        mem[a + 10'd2] <= bus.memWData[23:16];
        mem[a + 10'd3] <= bus.memWData[31:24];
      end
    end
  end

  always @(negedge clk) if (bus.memWEn) wen_cnt++;

  task automatic set_req(input logic v, input logic w,
                         input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] d);
    bus.reqValid = v;
    bus.reqWrite = w;
    bus.reqAddr  = a;
    bus.reqSize  = s;
    bus.reqWData = d;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    bus.memGnt = 1'b0;
    set_req(1'b1, 1'b1, 32'h40, 3'b010, 32'h1234);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.rspValid !== 1'b0 || bus.rspData !== 32'd0 ||
        bus.sbEmpty !== 1'b1 || bus.memWEn !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: rspValid=%b rspData=%h sbEmpty=%b memWEn=%b want 0 0 1 0",
               bus.rspValid, bus.rspData, bus.sbEmpty, bus.memWEn);
    end
    rstN = 1'b1;
    #1;
    checks++;
    if (bus.reqReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", bus.reqReady);
    end
    bus.reqValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_drain();
    bus.memGnt = 1'b1;
    set_req(1'b1, 1'b1, 32'h100, 3'b010, 32'hCAFEBABE);
    #1;
    checks++;
    if (bus.reqReady !== 1'b1) begin
      failures++;
      $display("FAIL sw_ready: got %b want 1", bus.reqReady);
    end
    @(negedge clk);
    bus.reqValid = 1'b0;
    #1;
    checks++;
    if (bus.rspValid !== 1'b1 || bus.rspErr !== 1'b0 ||
        bus.rspData !== 32'd0) begin
      failures++;
      $display("FAIL sw_rsp: v=%b err=%b data=%h want 1 0 0",
               bus.rspValid, bus.rspErr, bus.rspData);
    end
    checks++;
    if (bus.memWEn !== 1'b1 || bus.memAddr !== 32'h100 ||
        bus.memSize !== 3'b010 || bus.memWData !== 32'hCAFEBABE) begin
      failures++;
      $display("FAIL sw_port: wen=%b addr=%h size=%b data=%h want 1 100 010 cafebabe",
               bus.memWEn, bus.memAddr, bus.memSize, bus.memWData);
    end
    @(negedge clk);
    checks++;
    if (bus.sbEmpty !== 1'b1 || bus.rspValid !== 1'b0 ||
        bus.memWEn !== 1'b0 || bus.memSize !== 3'b011) begin
      failures++;
      $display("FAIL sw_after: empty=%b rspValid=%b wen=%b size=%b want 1 0 0 011",
               bus.sbEmpty, bus.rspValid, bus.memWEn, bus.memSize);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bus.memGnt = 1'b0;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 1'b1, 32'h300 + 32'(4 * i), 3'b010,
              32'h11110000 + 32'(i));
      #1;
      checks++;
      if (bus.reqReady !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready%0d: got %b want 1", i, bus.reqReady);
      end
      @(negedge clk);
    end
    set_req(1'b1, 1'b1, 32'h310, 3'b010, 32'h11110004);
    #1;
    checks++;
    if (bus.reqReady !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full: got %b want 0", bus.reqReady);
    end
    @(negedge clk);
    bus.memGnt = 1'b1;
    #1;
    checks++;
    if (bus.reqReady !== 1'b0 || bus.memWEn !== 1'b1 ||
        bus.memAddr !== 32'h300) begin
      failures++;
      $display("FAIL b2b_popfull: ready=%b wen=%b addr=%h want 0 1 300",
               bus.reqReady, bus.memWEn, bus.memAddr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.reqReady !== 1'b1 || bus.memAddr !== 32'h304) begin
      failures++;
      $display("FAIL b2b_fifth: ready=%b addr=%h want 1 304",
               bus.reqReady, bus.memAddr);
    end
    @(negedge clk);
    bus.reqValid = 1'b0;
    k = 0;
    while (k < 20 && bus.sbEmpty !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (bus.sbEmpty !== 1'b1 || log_addr.size() != 5) begin
      failures++;
      $display("FAIL b2b_drain: empty=%b writes=%0d want 1 5",
               bus.sbEmpty, log_addr.size());
    end
    if (log_addr.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_addr[i] !== 32'h300 + 32'(4 * i) ||
            log_data[i] !== 32'h11110000 + 32'(i) ||
            (i > 0 && log_cyc[i] != log_cyc[i-1] + 1)) begin
          failures++;
          $display("FAIL b2b_order%0d: addr=%h data=%h cyc=%0d want %h %h consecutive",
                   i, log_addr[i], log_data[i], log_cyc[i],
                   32'h300 + 32'(4 * i), 32'h11110000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_load_after_store(input logic [2:0] sz,
                                       input logic [31:0] exp);
    bus.memGnt = 1'b0;
    set_req(1'b1, 1'b1, 32'h200, 3'b000, 32'h00000080);
    @(negedge clk);
    set_req(1'b1, 1'b0, 32'h200, sz, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.reqReady !== 1'b0 || bus.memWEn !== 1'b0) begin
        failures++;
        $display("FAIL ld_blocked%0d: ready=%b wen=%b want 0 0",
                 i, bus.reqReady, bus.memWEn);
      end
      @(negedge clk);
    end
    bus.memGnt = 1'b1;
    #1;
    checks++;
    if (bus.reqReady !== 1'b0 || bus.memWEn !== 1'b1) begin
      failures++;
      $display("FAIL ld_drain: ready=%b wen=%b want 0 1",
               bus.reqReady, bus.memWEn);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.reqReady !== 1'b1 || bus.memAddr !== 32'h200 ||
        bus.memSize !== sz || bus.memWEn !== 1'b0) begin
      failures++;
      $display("FAIL ld_issue: ready=%b addr=%h size=%b wen=%b want 1 200 %b 0",
               bus.reqReady, bus.memAddr, bus.memSize, bus.memWEn, sz);
    end
    @(negedge clk);
    bus.reqValid = 1'b0;
    checks++;
    if (bus.rspValid !== 1'b1 || bus.rspErr !== 1'b0 ||
        bus.rspData !== exp) begin
      failures++;
      $display("FAIL ld_rsp_%b: v=%b err=%b data=%h want 1 0 %h",
               sz, bus.rspValid, bus.rspErr, bus.rspData, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_load_sizes();
    logic [2:0]  szs [3];
    logic [31:0] exps [3];
    bus.memGnt = 1'b1;
    set_req(1'b1, 1'b1, 32'h240, 3'b010, 32'h8001ABCD);
    @(negedge clk);
    bus.reqValid = 1'b0;
    @(negedge clk);
    szs  = '{3'b001, 3'b101, 3'b010};
    exps = '{32'hFFFFABCD, 32'h0000ABCD, 32'h8001ABCD};
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b0, 32'h240, szs[i], 32'd0);
      @(negedge clk);
      bus.reqValid = 1'b0;
      checks++;
      if (bus.rspValid !== 1'b1 || bus.rspData !== exps[i]) begin
        failures++;
        $display("FAIL ld_size_%b: v=%b data=%h want 1 %h",
                 szs[i], bus.rspValid, bus.rspData, exps[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic        ws [4];
    logic [31:0] as [4];
    logic [2:0]  ss [4];
    int          w0;
    ws = '{1'b0, 1'b0, 1'b1, 1'b1};
    as = '{32'h102, 32'h101, 32'h203, 32'h200};
    ss = '{3'b010, 3'b001, 3'b010, 3'b100};
    bus.memGnt = 1'b1;
    w0 = wen_cnt;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, ws[i], as[i], ss[i], 32'hDEADBEEF);
      #1;
      checks++;
      if (bus.reqReady !== 1'b1 || bus.memWEn !== 1'b0) begin
        failures++;
        $display("FAIL err_ready%0d: ready=%b wen=%b want 1 0",
                 i, bus.reqReady, bus.memWEn);
      end
      @(negedge clk);
      bus.reqValid = 1'b0;
      checks++;
      if (bus.rspValid !== 1'b1 || bus.rspErr !== 1'b1 ||
          bus.rspData !== 32'd0 || bus.sbEmpty !== 1'b1) begin
        failures++;
        $display("FAIL err_rsp%0d: v=%b err=%b data=%h empty=%b want 1 1 0 1",
                 i, bus.rspValid, bus.rspErr, bus.rspData, bus.sbEmpty);
      end
    end
    @(negedge clk);
    checks++;
    if (wen_cnt != w0 || bus.sbEmpty !== 1'b1) begin
      failures++;
      $display("FAIL err_nowrite: writes=%0d empty=%b want 0 1",
               wen_cnt - w0, bus.sbEmpty);
    end
  endtask

  task automatic test_reset_discard();
    bus.memGnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b1, 32'h380 + 32'(4 * i), 3'b010, 32'h5A5A0000);
      @(negedge clk);
    end
    bus.reqValid = 1'b0;
    checks++;
    if (bus.sbEmpty !== 1'b0) begin
      failures++;
      $display("FAIL rd_filled: empty=%b want 0", bus.sbEmpty);
    end
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    bus.memGnt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bus.memWEn !== 1'b0 || bus.sbEmpty !== 1'b1) begin
        failures++;
        $display("FAIL rd_quiet%0d: wen=%b empty=%b want 0 1",
                 i, bus.memWEn, bus.sbEmpty);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
    bus.memGnt = 1'b0;
    set_req(1'b0, 1'b0, 32'd0, 3'b000, 32'd0);
    @(negedge clk);
    test_reset();
    test_store_drain();
    test_back_to_back();
    test_load_after_store(3'b000, 32'hFFFFFF80);
    test_load_after_store(3'b100, 32'h00000080);
    test_load_sizes();
    test_errors();
    test_reset_discard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_store_buffer.md
Name: lsu_store_buffer

Overview:
- Load/store unit that sits in the MEM stage, directly upstream of the byte-addressed data memory.
- Accepts one load or store request per cycle from the pipeline and checks size/alignment.
- Stores are posted into a FIFO store buffer and drained to the memory port one per cycle when the port is granted.
- Loads go straight to the memory port only when the buffer is empty (no forwarding). Read data is registered into a one-cycle response.

Parameters:
SB_DEPTH, 4, number of store-buffer entries; power of two, >= 2

Ports:
clk  in  1  clock, all state on rising edge
rstN  in  1  synchronous active-low reset
reqValid  in  1  pipeline request valid
reqReady  out  1  request accepted this cycle when reqValid & reqReady
reqWrite  in  1  1 = store, 0 = load
reqAddr  in  32  byte address
reqSize  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
reqWData  in  32  store data, low bytes significant
rspValid  out  1  one-cycle response pulse
rspData  out  32  load result; 0 for stores and errors
rspErr  out  1  misaligned or illegal access
memGnt  in  1  memory port available this cycle
memAddr  out  32  to memory addr
memSize  out  3  to memory size
memWData  out  32  to memory write data
memWEn  out  1  to memory write enable
memRData  in  32  from memory, combinational read data
sbEmpty  out  1  store buffer holds no entries

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-low (rstN).
- Reset values: rspValid=0, rspData=0, rspErr=0. FIFO rd/wr pointers=0, count=0, so sbEmpty=1.
- Reset mid-operation discards all buffered stores; no memWEn is issued after reset for pre-reset entries.
- Legality:
  - Load sizes 000/100: any address.
  - Load sizes 001/101: addr[0]=0.
  - Load size 010: addr[1:0]=00.
  - Store sizes 000/001/010 only, same alignment rules.
  - Every other size/op combination is illegal.
- Error request:
  - reqReady=1 always; no buffer push and no memory access.
  - Next cycle: rspValid=1, rspErr=1, rspData=0.
- Legal store:
  - reqReady = (count != SB_DEPTH), using the registered count. A full buffer does not accept a store even if a drain pops the same cycle.
  - On accept, push {addr,size,wData}.
  - Next cycle: rspValid=1, rspErr=0, rspData=0.
- Legal load:
  - reqReady = sbEmpty & memGnt.
  - On accept, drive the port combinationally in the same cycle: memAddr=reqAddr, memSize=reqSize, memWEn=0.
  - Register memRData into rspData; next cycle rspValid=1, rspErr=0.
  - Latency 1 cycle.
- Drain FSM, states IDLE (count=0) and DRAIN (count>0):
  - In DRAIN with memGnt=1: drive the head entry with memWEn=1 and pop at the clock edge.
  - In DRAIN with memGnt=0: memWEn=0 and the head is held.
  - A push and a pop in the same cycle leave count unchanged.
  - DRAIN goes to IDLE when the last entry is popped with no push in that cycle.
  - The earliest drain of an entry is the cycle after its push.
- Port priority: a load can be accepted only in IDLE, so load and drain never conflict.
- Port idle values: memAddr=0, memSize=3'b011, memWData=0, memWEn=0.
- Pointer arithmetic: $clog2(SB_DEPTH) bits, natural wrap-around. count is $clog2(SB_DEPTH)+1 bits.
- No response backpressure: exactly one rspValid pulse per accepted request, in order.
- Address passes through unmodified; memory handles high-bit masking.

Test Plan:
1. Reset: rstN=0 for 2 cycles with reqValid=1 -> rspValid=0, rspData=0, sbEmpty=1, memWEn=0. After release, store reqReady=1.
2. Store W addr 0x100 data 0xCAFEBABE, memGnt=1, accepted cycle 0 -> cycle 1: rspValid=1, rspErr=0, memWEn=1, memAddr=0x100, memSize=010, memWData=0xCAFEBABE. Cycle 2: sbEmpty=1.
3. memGnt=0, 5 back-to-back stores, SB_DEPTH=4:
   - First 4 accepted; 5th sees reqReady=0.
   - Raise memGnt -> writes emerge in order, one per cycle.
   - 5th accepted the cycle after the first pop.
4. Store B 0x80 to addr 0x200, then load B addr 0x200 with memGnt=0 for 3 cycles -> load reqReady=0 until drain. Raise memGnt -> load accepted after drain; next-cycle rspData=0xFFFFFF80. Same sequence with LBU -> 0x00000080.
5. LW 0x102, LH 0x101, SW 0x203, store size 100 -> each: reqReady=1, next cycle rspErr=1, rspData=0. No memWEn, sbEmpty stays 1.
6. 3 stores buffered with memGnt=0, then rstN=0 one cycle, then memGnt=1 -> sbEmpty=1, memWEn stays 0 for 10 cycles.
